// File: rtl/fetch_ctrl_if.sv
// Bundle between the pipeline and the fetch control unit: redirect/stall
// requests in, program-memory control and flush out.
`default_nettype none

interface fetch_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 4
);
   logic              branch_req;
   logic [ADDR_W-1:0] branch_target;
   logic              jump_req;
   logic [ADDR_W-1:0] jump_target;
   logic              hazard_stall;
   logic              mc_start;
   logic [CNT_W-1:0]  mc_cycles;
   logic              pc_mux_sel;
   logic [ADDR_W-1:0] jmp_loc;
   logic              stall;
   logic              stall_pm;
   logic              flush;
   logic              busy;

   modport master (
      output branch_req, branch_target, jump_req, jump_target,
             hazard_stall, mc_start, mc_cycles,
      input  pc_mux_sel, jmp_loc, stall, stall_pm, flush, busy
   );

   modport slave (
      input  branch_req, branch_target, jump_req, jump_target,
             hazard_stall, mc_start, mc_cycles,
      output pc_mux_sel, jmp_loc, stall, stall_pm, flush, busy
   );
endinterface

`default_nettype wire

// File: rtl/fetch_control_unit.sv
// Fetch-stage sequencer: arbitrates redirects, multi-cycle stalls and load-use
// stalls, queuing one redirect that arrives while a multi-cycle stall is active.
`default_nettype none

module fetch_control_unit #(
   parameter int ADDR_W       = 16,
   parameter int CNT_W        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  wire logic   clk,
   input  wire logic   reset,
   fetch_ctrl_if.slave fc
);
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_WAIT = 2'd1,
      REDIR   = 2'd2,
      FLUSH   = 2'd3
   } state_t;

   localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        fcnt;
   logic              pend_v;
   logic [ADDR_W-1:0] pend_addr;
   logic              stall_d;

   logic              redir_req;
   logic [ADDR_W-1:0] redir_addr;
   logic              mc_go;
   logic              pc_mux_sel_c;
   logic [ADDR_W-1:0] jmp_loc_c;
   logic              stall_c;
   logic              flush_c;

   // The branch comes from EX and is therefore older than a jump in ID.
   always_comb begin
      redir_req    = fc.branch_req | fc.jump_req;
      redir_addr   = fc.branch_req ? fc.branch_target : fc.jump_target;
      mc_go        = fc.mc_start && (fc.mc_cycles != '0);
      pc_mux_sel_c = 1'b0;
      jmp_loc_c    = '0;
      stall_c      = 1'b0;
      flush_c      = 1'b0;
      case (state)
         RUN: begin
            if (redir_req) begin
               pc_mux_sel_c = 1'b1;
               jmp_loc_c    = redir_addr;
            end else if (mc_go || fc.hazard_stall) begin
               stall_c = 1'b1;
            end
         end
         MC_WAIT: stall_c = 1'b1;
         REDIR: begin
            pc_mux_sel_c = 1'b1;
            jmp_loc_c    = pend_addr;
         end
         FLUSH: flush_c = 1'b1;
         default: ;
      endcase
      if (reset) begin
         pc_mux_sel_c = 1'b0;
         jmp_loc_c    = '0;
         stall_c      = 1'b0;
         flush_c      = 1'b0;
      end
   end

   assign fc.pc_mux_sel = pc_mux_sel_c;
   assign fc.jmp_loc    = jmp_loc_c;
   assign fc.stall      = stall_c;
   assign fc.stall_pm   = stall_d;
   assign fc.flush      = flush_c;
   assign fc.busy       = (state != RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         cnt       <= '0;
         fcnt      <= '0;
         pend_v    <= 1'b0;
         pend_addr <= '0;
         stall_d   <= 1'b0;
      end else begin
         stall_d <= stall_c;
         case (state)
            RUN: begin
               if (redir_req) begin
                  state <= FLUSH;
                  fcnt  <= FCNT_INIT;
               end else if (mc_go && (fc.mc_cycles != CNT_W'(1))) begin
                  state <= MC_WAIT;
                  cnt   <= fc.mc_cycles - CNT_W'(1);
               end
            end
            MC_WAIT: begin
               if (redir_req && !pend_v) begin
                  pend_v    <= 1'b1;
                  pend_addr <= redir_addr;
               end
               // cnt holds at 1 on exit so it never wraps.
               if (cnt <= CNT_W'(1)) begin
                  state <= (pend_v || redir_req) ? REDIR : RUN;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            REDIR: begin
               pend_v <= 1'b0;
               state  <= FLUSH;
               fcnt   <= FCNT_INIT;
            end
            FLUSH: begin
               if (fcnt == 2'd0) begin
                  state <= RUN;
               end else begin
                  fcnt <= fcnt - 2'd1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

`default_nettype wire
